trng_fetch_ctrl: RTL and testbench

//  Requesting side of the TRNG 4-phase handshake (trng_request/ready/random_number).

---
 rtl/trng_fetch_ctrl_if.sv | 25 ++
 rtl/trng_fetch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_trng_fetch_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_fetch_ctrl_if.sv
// TRNG fetch controller bus: TRNG handshake plus the consumer valid/pop port.
// master = controller side, slave = TRNG/consumer side.
interface trng_fetch_ctrl_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    logic            trng_request;
    logic            trng_ready;
    logic [31:0]     trng_data;
    logic            rnd_valid;
    logic [31:0]     rnd_data;
    logic            rnd_pop;
    logic [LvlW-1:0] fifo_level;

    modport master (
        output trng_request, rnd_valid, rnd_data, fifo_level,
        input  trng_ready, trng_data, rnd_pop
    );

    modport slave (
        input  trng_request, rnd_valid, rnd_data, fifo_level,
        output trng_ready, trng_data, rnd_pop
    );
endinterface

// File: rtl/trng_fetch_ctrl.sv
// Fetches 32-bit words from the TRNG 4-phase handshake into a small FIFO.
// Optional repetition health test is built only when TRNG_HEALTH_EN is defined.
module trng_fetch_ctrl #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned HEALTH_CUTOFF  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    trng_fetch_ctrl_if.master   bus,
    output logic                timeout_pulse,
    output logic                health_fail
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned TcntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TcntW-1:0] TcntMax = TcntW'(TIMEOUT_CYCLES - 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 64) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 64");
    end
    if (HEALTH_CUTOFF < 1) begin : g_bad_cutoff
        $error("HEALTH_CUTOFF must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e            state_q, state_d;
    logic [TcntW-1:0]  tcnt_q, tcnt_d;
    logic [31:0]       cap_q, cap_d;
    logic              cap_vld_q, cap_vld_d;
    logic              req_q, req_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PtrW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic              push, pop, flush;

`ifdef TRNG_HEALTH_EN
    localparam int unsigned RepW = $clog2(HEALTH_CUTOFF + 1);
    logic [31:0]     last_q, last_d;
    logic            last_vld_q, last_vld_d;
    logic [RepW-1:0] rep_q, rep_d;
    logic            health_q, health_d;
`endif

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        cap_d     = cap_q;
        cap_vld_d = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
`ifdef TRNG_HEALTH_EN
                if (enable && (level_q < LvlW'(DEPTH)) && !health_q) begin
`else
                if (enable && (level_q < LvlW'(DEPTH))) begin
`endif
                    state_d = StReq;
                    tcnt_d  = '0;
                end
            end
            StReq: begin
                if (bus.trng_ready) begin
                    cap_d     = bus.trng_data;
                    cap_vld_d = 1'b1;
                    state_d   = StDrop;
                end else if (tcnt_q == TcntMax) begin
                    timeout_d = 1'b1;
                    state_d   = StDrop;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StDrop: begin
                if (!bus.trng_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        req_d = (state_d == StReq);

        // Captured word is pushed one cycle after ready was sampled.
        push  = cap_vld_q;
        flush = 1'b0;
`ifdef TRNG_HEALTH_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
        rep_d      = rep_q;
        health_d   = health_q;
        if (cap_vld_q) begin
            last_d     = cap_q;
            last_vld_d = 1'b1;
            if (last_vld_q && (cap_q == last_q)) begin
                push = 1'b0;
                if (rep_q == RepW'(HEALTH_CUTOFF - 1)) health_d = 1'b1;
                else rep_d = rep_q + 1'b1;
            end else begin
                rep_d = '0;
            end
        end
        flush = health_d;
`endif

        pop     = bus.rnd_pop && (level_q != '0);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (push) begin
            mem_d[wr_q] = cap_q;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        level_d = level_q + LvlW'(push) - LvlW'(pop);
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end
        // Reading mem_d gives write-through when a push lands on the new head.
        valid_d = (level_d != '0);
        data_d  = valid_d ? mem_d[rd_d] : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tcnt_q    <= '0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
            req_q     <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
`ifdef TRNG_HEALTH_EN
            last_q     <= '0;
            last_vld_q <= 1'b0;
            rep_q      <= '0;
            health_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
            req_q     <= req_d;
            timeout_q <= timeout_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
`ifdef TRNG_HEALTH_EN
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            rep_q      <= rep_d;
            health_q   <= health_d;
`endif
        end
    end

    assign bus.trng_request = req_q;
    assign bus.rnd_valid    = valid_q;
    assign bus.rnd_data     = data_q;
    assign bus.fifo_level   = level_q;
    assign timeout_pulse    = timeout_q;
`ifdef TRNG_HEALTH_EN
    assign health_fail      = health_q;
`else
    assign health_fail      = 1'b0;
`endif
endmodule

// File: tb/tb_trng_fetch_ctrl.sv
// Self-checking bench for trng_fetch_ctrl: TRNG responder model plus a queue-based FIFO model.
module tb_trng_fetch_ctrl;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LvlW  = $clog2(DEPTH) + 1;
    localparam int unsigned CUTOFF = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic timeout_pulse, health_fail;
    int   checks = 0;
    int   errors = 0;

    trng_fetch_ctrl_if #(.DEPTH(DEPTH)) bus ();

    trng_fetch_ctrl #(
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(256),
        .HEALTH_CUTOFF(CUTOFF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .bus(bus),
        .timeout_pulse(timeout_pulse),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    // TRNG responder: ready rises after 32 cycles of request, drops once request drops.
    logic [31:0] base = 32'h0;
    bit          const_mode = 1'b0;
    bit          stuck = 1'b0;
    int          req_cnt;
    int          nfetch;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.trng_ready <= 1'b0;
            bus.trng_data  <= 32'h0;
            req_cnt        <= 0;
            nfetch         <= 0;
        end else if (bus.trng_ready) begin
            if (!bus.trng_request) bus.trng_ready <= 1'b0;
        end else if (bus.trng_request && !stuck) begin
            if (req_cnt == 31) begin
                bus.trng_ready <= 1'b1;
                bus.trng_data  <= const_mode ? base : base + 32'(nfetch);
                nfetch         <= nfetch + 1;
                req_cnt        <= 0;
            end else begin
                req_cnt <= req_cnt + 1;
            end
        end else begin
            req_cnt <= 0;
        end
    end

    // Reference model: words accepted by the handshake, pushed one cycle later, popped in order.
    logic [31:0] exp_q [$];
    bit          pend;
    logic [31:0] pend_word;
    bit          has_last;
    logic [31:0] last_word;
    int          reps;
    bit          exp_health;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            pend = 1'b0;
            has_last = 1'b0;
            reps = 0;
            exp_health = 1'b0;
        end else begin
            if (bus.rnd_pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (pend) begin
`ifdef TRNG_HEALTH_EN
                if (has_last && pend_word == last_word) begin
                    reps++;
                    if (reps >= CUTOFF) exp_health = 1'b1;
                end else begin
                    exp_q.push_back(pend_word);
                    reps = 0;
                end
                last_word = pend_word;
                has_last = 1'b1;
`else
                exp_q.push_back(pend_word);
`endif
            end
            if (exp_health) exp_q.delete();
            pend = bus.trng_request && bus.trng_ready;
            pend_word = bus.trng_data;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        bus.rnd_pop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        bus.rnd_pop = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.trng_request, bus.rnd_valid, timeout_pulse, health_fail} !== 4'b0)
            $display("FAIL reset_flags: got req/valid/to/hf=%b want 0000",
                     {bus.trng_request, bus.rnd_valid, timeout_pulse, health_fail});
        if ({bus.trng_request, bus.rnd_valid, timeout_pulse, health_fail} !== 4'b0) errors++;
        checks++;
        if (bus.rnd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", bus.rnd_data);
        end
        checks++;
        if (bus.fifo_level !== '0) begin
            errors++;
            $display("FAIL reset_level: got %0d want 0", bus.fifo_level);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        int reqs;
        base = 32'hA5A5_0001;
        const_mode = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 400 && exp_q.size() < DEPTH; c++) begin
            @(negedge clk);
            checks++;
            if (bus.fifo_level !== LvlW'(exp_q.size())) begin
                errors++;
                $display("FAIL fill_level: got %0d want %0d", bus.fifo_level, exp_q.size());
            end
        end
        @(negedge clk);
        checks++;
        if (bus.fifo_level !== LvlW'(DEPTH)) begin
            errors++;
            $display("FAIL fill_full: got %0d want %0d", bus.fifo_level, DEPTH);
        end
        checks++;
        if (bus.rnd_data !== 32'hA5A5_0001 || bus.rnd_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_head: got %h/%b want a5a50001/1", bus.rnd_data, bus.rnd_valid);
        end
        reqs = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.trng_request) reqs++;
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL full_no_request: got %0d request cycles want 0", reqs);
        end
    endtask

    task automatic test_drain();
        bit seen_req = 1'b0;
        int max_lvl = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (bus.trng_request) seen_req = 1'b1;
            checks++;
            if (bus.rnd_data !== 32'hA5A5_0001 + 32'(i) || bus.rnd_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_order[%0d]: got %h want %h", i, bus.rnd_data,
                         32'hA5A5_0001 + 32'(i));
            end
            bus.rnd_pop = 1'b1;
        end
        @(negedge clk);
        bus.rnd_pop = 1'b0;
        if (bus.trng_request) seen_req = 1'b1;
        checks++;
        if (!seen_req) begin
            errors++;
            $display("FAIL drain_refetch: got no request want request once level<4");
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
        end
        checks++;
        if (max_lvl > DEPTH || bus.fifo_level !== LvlW'(DEPTH)) begin
            errors++;
            $display("FAIL drain_level: got max %0d final %0d want max<=4 final 4", max_lvl,
                     bus.fifo_level);
        end
        checks++;
        if (bus.rnd_data !== 32'hA5A5_0005) begin
            errors++;
            $display("FAIL drain_next_word: got %h want a5a50005", bus.rnd_data);
        end
    endtask

    task automatic test_random();
        int since = 1000;
        bit prev_req = 1'b0;
        int bad = 0;
        base = $urandom;
        const_mode = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            checks++;
            if (bus.fifo_level !== LvlW'(exp_q.size()) ||
                bus.rnd_valid !== (exp_q.size() > 0) ||
                (exp_q.size() > 0 && bus.rnd_data !== exp_q[0])) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL random_fifo@%0d: got lvl %0d data %h want lvl %0d data %h", c,
                             bus.fifo_level, bus.rnd_data, exp_q.size(),
                             exp_q.size() > 0 ? exp_q[0] : 32'h0);
            end
            if (bus.trng_request && !prev_req) begin
                checks++;
                if (since < 35 || bus.trng_ready) begin
                    errors++;
                    $display("FAIL random_period: got gap %0d ready %b want gap>=35 ready 0",
                             since, bus.trng_ready);
                end
                since = 0;
            end else begin
                since++;
            end
            prev_req = bus.trng_request;
            bus.rnd_pop = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
        end
        bus.rnd_pop = 1'b0;
    endtask

    task automatic test_timeout();
        int hcnt;
        bit seen;
        stuck = 1'b1;
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < 2; t++) begin
            hcnt = 0;
            seen = 1'b0;
            for (int c = 0; c < 400 && !seen; c++) begin
                @(negedge clk);
                if (bus.trng_request) hcnt++;
                if (timeout_pulse) seen = 1'b1;
            end
            checks++;
            if (!seen || hcnt != 256 || bus.trng_request !== 1'b0) begin
                errors++;
                $display("FAIL timeout_%0d: got seen %b req cycles %0d req %b want 1 256 0", t,
                         seen, hcnt, bus.trng_request);
            end
            @(negedge clk);
            checks++;
            if (timeout_pulse !== 1'b0 || bus.fifo_level !== '0) begin
                errors++;
                $display("FAIL timeout_width_%0d: got pulse %b lvl %0d want 0 0", t,
                         timeout_pulse, bus.fifo_level);
            end
        end
        stuck = 1'b0;
    endtask

    task automatic test_midreset();
        int hcnt = 0;
        bit done = 1'b0;
        base = $urandom;
        const_mode = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 100 && hcnt < 10; c++) begin
            @(negedge clk);
            if (bus.trng_request) hcnt++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.trng_request, bus.rnd_valid, timeout_pulse, health_fail} !== 4'b0 ||
            bus.rnd_data !== 32'h0 || bus.fifo_level !== '0 || hcnt != 10) begin
            errors++;
            $display("FAIL midreset: got req %b valid %b lvl %0d data %h hcnt %0d want zeros/10",
                     bus.trng_request, bus.rnd_valid, bus.fifo_level, bus.rnd_data, hcnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.fifo_level == 1) done = 1'b1;
        end
        checks++;
        if (!done || bus.rnd_data !== base) begin
            errors++;
            $display("FAIL midreset_refetch: got done %b data %h want 1 %h", done, bus.rnd_data,
                     base);
        end
    endtask

    task automatic test_pushpop();
        logic [31:0] want;
        bit hit = 1'b0;
        base = $urandom;
        const_mode = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk);
            if (exp_q.size() == 2 && pend) begin
                want = exp_q[1];
                bus.rnd_pop = 1'b1;
                hit = 1'b1;
            end
        end
        @(negedge clk);
        bus.rnd_pop = 1'b0;
        checks++;
        if (!hit || bus.fifo_level !== LvlW'(2)) begin
            errors++;
            $display("FAIL pushpop_level: got hit %b lvl %0d want 1 2", hit, bus.fifo_level);
        end
        checks++;
        if (bus.rnd_data !== want || want !== base + 32'h1) begin
            errors++;
            $display("FAIL pushpop_order: got %h want %h", bus.rnd_data, base + 32'h1);
        end
    endtask

    task automatic test_health();
        int max_lvl = 0;
        int reqs = 0;
        base = 32'hDEAD_BEEF;
        const_mode = 1'b1;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
            if (c >= 500 && bus.trng_request) reqs++;
        end
`ifdef TRNG_HEALTH_EN
        checks++;
        if (health_fail !== 1'b1 || bus.fifo_level !== '0 || bus.rnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL health_trip: got hf %b lvl %0d valid %b want 1 0 0", health_fail,
                     bus.fifo_level, bus.rnd_valid);
        end
        checks++;
        if (max_lvl != 1 || reqs != 0) begin
            errors++;
            $display("FAIL health_block: got max lvl %0d late reqs %0d want 1 0", max_lvl, reqs);
        end
`else
        checks++;
        if (health_fail !== 1'b0 || bus.fifo_level !== LvlW'(4) || bus.rnd_data !== base) begin
            errors++;
            $display("FAIL health_off: got hf %b lvl %0d data %h want 0 4 deadbeef",
                     health_fail, bus.fifo_level, bus.rnd_data);
        end
        checks++;
        if (max_lvl != 4 || reqs != 0) begin
            errors++;
            $display("FAIL health_off_fill: got max lvl %0d reqs %0d want 4 0", max_lvl, reqs);
        end
`endif
        const_mode = 1'b0;
    endtask

    initial begin
        bus.rnd_pop = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_random();
        test_timeout();
        test_midreset();
        test_pushpop();
        test_health();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
